// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_DIV = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_MUL = 4'h7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/alu_div_seq.sv
// Restoring unsigned divider, one quotient bit per cycle. The first bit is
// resolved on the start cycle, so done pulses WIDTH-1 cycles after start.
module alu_div_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] src_rem;
  logic [WIDTH-1:0] src_quo;
  logic [WIDTH-1:0] src_dsr;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  // One restoring step on either the freshly loaded operands or the running state
  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    src_dsr = start ? divisor : dsr_q;
    rem_sh  = {src_rem, src_quo[WIDTH-1]};
    trial   = rem_sh - {1'b0, src_dsr};
  end

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start || busy_q) begin
      dsr_d = src_dsr;
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {src_quo[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[WIDTH-1:0];
        quo_d = {src_quo[WIDTH-2:0], 1'b0};
      end
      if (start) begin
        cnt_d  = CW'(WIDTH - 1);
        busy_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential unsigned ALU: single-cycle ADD/SUB/MUL, iterative DIV, with a
// valid/ready handshake on both the operation and the result side.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Res1,
  output logic [WIDTH-1:0] Res2,
  output logic             cout,
  output logic             zero,
  output logic             dbz
);

  localparam int unsigned PW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res1_q, res1_d;
  logic [WIDTH-1:0] res2_q, res2_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic             accept;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [PW-1:0]    prod;

  // Reset overrides the registered ready so nothing is taken while rst is high
  assign in_ready = in_ready_q && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    sum  = {1'b0, A} + {1'b0, B};
    diff = A - B;
    prod = PW'(A) * PW'(B);
  end

  always_comb begin
    state_d     = state_q;
    res1_d      = res1_q;
    res2_d      = res2_q;
    cout_d      = cout_q;
    zero_d      = zero_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;
    div_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (sel)
            OP_ADD: begin
              res1_d      = sum[WIDTH-1:0];
              res2_d      = '0;
              cout_d      = sum[WIDTH];
              zero_d      = (sum[WIDTH-1:0] == '0);
              dbz_d       = 1'b0;
              out_valid_d = 1'b1;
              state_d     = DONE;
            end
            OP_SUB: begin
              res1_d      = diff;
              res2_d      = '0;
              cout_d      = (A < B);
              zero_d      = (diff == '0);
              dbz_d       = 1'b0;
              out_valid_d = 1'b1;
              state_d     = DONE;
            end
            OP_MUL: begin
              res1_d      = prod[WIDTH-1:0];
              res2_d      = prod[PW-1:WIDTH];
              cout_d      = 1'b0;
              zero_d      = (prod == '0);
              dbz_d       = 1'b0;
              out_valid_d = 1'b1;
              state_d     = DONE;
            end
            OP_DIV: begin
              if (B == '0) begin
                res1_d      = '1;
                res2_d      = A;
                cout_d      = 1'b0;
                zero_d      = 1'b0;
                dbz_d       = 1'b1;
                out_valid_d = 1'b1;
                state_d     = DONE;
              end else begin
                div_start = 1'b1;
                state_d   = DIV_RUN;
              end
            end
            OP_NOP: begin
            end
            default: begin
            end
          endcase
        end
      end
      DIV_RUN: begin
        if (div_done && !div_busy) begin
          res1_d      = div_quo;
          res2_d      = div_rem;
          cout_d      = 1'b0;
          zero_d      = (div_quo == '0);
          dbz_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      res1_q      <= '0;
      res2_q      <= '0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      res1_q      <= res1_d;
      res2_q      <= res2_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Operands are captured inside the divider at start
  alu_div_seq #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (A),
    .divisor  (B),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  assign out_valid = out_valid_q;
  assign Res1      = res1_q;
  assign Res2      = res2_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8.
module tb_alu_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Res1;
  logic [W-1:0] Res2;
  logic         cout;
  logic         zero;
  logic         dbz;

  int checks = 0;
  int errors = 0;
  int lat;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .sel      (sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Res1     (Res1),
    .Res2     (Res2),
    .cout     (cout),
    .zero     (zero),
    .dbz      (dbz)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    sel      = op;
    A        = a;
    B        = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; sel = 4'h0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_res1", Res1, 8'h00);
    chk("rst_res2", Res2, 8'h00);
    chk("rst_flags", {cout, zero, dbz}, 3'b000);
    chk("rst_in_ready_held", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1'b1);

    // ADD 200+100 = 300 -> 0x12C
    issue(4'h3, 8'd200, 8'd100);
    chk("add_valid", out_valid, 1'b1);
    chk("add_res1", Res1, 8'h2C);
    chk("add_res2", Res2, 8'h00);
    chk("add_cout", cout, 1'b1);
    chk("add_zero", zero, 1'b0);
    chk("add_in_ready", in_ready, 1'b0);
    drain();
    chk("add_drain_valid", out_valid, 1'b0);
    chk("add_drain_ready", in_ready, 1'b1);

    // SUB with borrow and SUB equal operands
    issue(4'h6, 8'd3, 8'd5);
    chk("sub_res1", Res1, 8'hFE);
    chk("sub_cout", cout, 1'b1);
    chk("sub_zero", zero, 1'b0);
    drain();
    issue(4'h6, 8'd9, 8'd9);
    chk("sub_eq_res1", Res1, 8'h00);
    chk("sub_eq_flags", {cout, zero}, 2'b01);
    drain();

    // MUL 255*255 = 0xFE01, then zero product
    issue(4'h7, 8'd255, 8'd255);
    chk("mul_valid", out_valid, 1'b1);
    chk("mul_res2", Res2, 8'hFE);
    chk("mul_res1", Res1, 8'h01);
    chk("mul_zero", zero, 1'b0);
    drain();
    issue(4'h7, 8'd0, 8'd77);
    chk("mul0_res", {Res2, Res1}, 16'h0000);
    chk("mul0_zero", zero, 1'b1);
    drain();

    // DIV 200/7 = 28 r 4, latency WIDTH+1
    issue(4'h4, 8'd200, 8'd7);
    A = 8'd1; B = 8'd1;
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("div_in_ready_busy", in_ready, 1'b0);
      tick();
      lat++;
    end
    chk("div_latency", lat, 9);
    chk("div_valid", out_valid, 1'b1);
    chk("div_res1", Res1, 8'd28);
    chk("div_res2", Res2, 8'd4);
    chk("div_dbz", dbz, 1'b0);
    chk("div_zero", zero, 1'b0);
    drain();

    // DIV by zero
    issue(4'h4, 8'd5, 8'd0);
    chk("dbz_valid", out_valid, 1'b1);
    chk("dbz_res1", Res1, 8'hFF);
    chk("dbz_res2", Res2, 8'd5);
    chk("dbz_flags", {cout, zero, dbz}, 3'b001);
    drain();

    // NOP and undefined opcode: no result, outputs hold
    issue(4'h0, 8'd1, 8'd2);
    chk("nop_valid", out_valid, 1'b0);
    chk("nop_ready", in_ready, 1'b1);
    chk("nop_hold", {Res1, Res2, cout, zero, dbz}, {8'hFF, 8'd5, 3'b001});
    issue(4'hA, 8'd1, 8'd2);
    chk("undef_valid", out_valid, 1'b0);
    chk("undef_hold", {Res1, Res2, cout, zero, dbz}, {8'hFF, 8'd5, 3'b001});

    // DIV with zero quotient
    issue(4'h4, 8'd0, 8'd3);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("div0_latency", lat, 9);
    chk("div0_res", {Res1, Res2}, 16'h0000);
    chk("div0_zero", zero, 1'b1);
    drain();

    // Back-pressure: result held, new op ignored until drained
    issue(4'h3, 8'd10, 8'd20);
    in_valid = 1'b1; sel = 4'h3; A = 8'd1; B = 8'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_res1", Res1, 8'h1E);
      chk("stall_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall_drain_valid", out_valid, 1'b0);
    chk("stall_drain_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("stall_next_valid", out_valid, 1'b1);
    chk("stall_next_res1", Res1, 8'h03);
    drain();

    // Reset during DIV_RUN aborts the divide
    issue(4'h4, 8'd200, 8'd7);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_outs", {Res1, Res2, cout, zero, dbz}, 19'h0);
    chk("abort_ready", in_ready, 1'b1);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("abort_no_late", out_valid, 1'b0);
    end

    // Wraparound add after reset
    issue(4'h3, 8'd255, 8'd1);
    chk("wrap_res1", Res1, 8'h00);
    chk("wrap_flags", {cout, zero}, 2'b11);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
